// File: rtl/d5m_sensor_emulator.sv
// d5m_sensor_emulator
//   Stand-in for the TRDB-D5M parallel pixel interface. Generates frames of
//   H_ACTIVE x V_ACTIVE pixels with configurable blanking and a selectable
//   test pattern. All outputs are registered from the current state, so they
//   trail the state register by exactly one pixel clock.
// Ports
//   im_PIXLCLK      pixel clock
//   im_RST          synchronous active-high reset
//   im_ENABLE       run request, sampled in IDLE and at the end of each frame
//   im_PATTERN_SEL  test pattern, latched on FV_PRE entry
//   om_D5M_D        12-bit pixel data, 0 outside LVAL
//   om_D5M_FVAL     frame valid
//   om_D5M_LVAL     line valid
//   om_FRAME_DONE   one-cycle pulse in the first FVAL-low cycle of a frame
//   om_FRAME_CNT    completed-frame count
module d5m_sensor_emulator #(
  parameter int H_ACTIVE = 16,
  parameter int V_ACTIVE = 8,
  parameter int H_BLANK  = 4,
  parameter int V_BLANK  = 20,
  parameter int FV_LEAD  = 2,
  parameter int FV_TRAIL = 2
) (
  input  logic        im_PIXLCLK,
  input  logic        im_RST,
  input  logic        im_ENABLE,
  input  logic [1:0]  im_PATTERN_SEL,
  output logic [11:0] om_D5M_D,
  output logic        om_D5M_FVAL,
  output logic        om_D5M_LVAL,
  output logic        om_FRAME_DONE,
  output logic [15:0] om_FRAME_CNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_VBLANK, S_FV_PRE, S_LINE, S_HBLANK, S_FV_POST
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;      // phase cycle counter for blanking states
  logic [11:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [1:0]  pat_q, pat_d;

  logic [11:0] d_q, d_d;
  logic        fval_q, fval_d;
  logic        lval_q, lval_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [11:0] pix;

  // state register
  always_ff @(posedge im_PIXLCLK) begin
    if (im_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pat_q   <= pat_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    x_d     = x_q;
    y_d     = y_q;
    pat_d   = pat_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (im_ENABLE) state_d = S_VBLANK;
      end
      S_VBLANK: begin
        if (cnt_q == 32'(V_BLANK - 1)) begin
          state_d = S_FV_PRE;
          cnt_d   = '0;
          pat_d   = im_PATTERN_SEL;
        end
      end
      S_FV_PRE: begin
        if (cnt_q == 32'(FV_LEAD - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_LINE: begin
        cnt_d = '0;
        x_d   = x_q + 12'd1;
        if (x_q == 12'(H_ACTIVE - 1)) begin
          state_d = (y_q == 16'(V_ACTIVE - 1)) ? S_FV_POST : S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (cnt_q == 32'(H_BLANK - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = y_q + 16'd1;
        end
      end
      S_FV_POST: begin
        if (cnt_q == 32'(FV_TRAIL - 1)) begin
          state_d = im_ENABLE ? S_VBLANK : S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // output logic: next values of the registered outputs, derived from state_q
  always_comb begin
    unique case (pat_q)
      2'd0:    pix = x_q;
      2'd1:    pix = y_q[11:0];
      2'd2:    pix = (x_q[3] ^ y_q[3]) ? 12'hFFF : 12'h000;
      default: pix = x_q + fcnt_q[11:0];
    endcase
    fval_d = (state_q != S_IDLE) && (state_q != S_VBLANK);
    lval_d = (state_q == S_LINE);
    d_d    = lval_d ? pix : 12'h000;
    // frame ends on the FVAL falling transition; count bumps in the same cycle
    done_d = fval_q & ~fval_d;
    fcnt_d = fcnt_q + {15'd0, done_d};
  end

  always_ff @(posedge im_PIXLCLK) begin
    if (im_RST) begin
      d_q    <= '0;
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      done_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      d_q    <= d_d;
      fval_q <= fval_d;
      lval_q <= lval_d;
      done_q <= done_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign om_D5M_D      = d_q;
  assign om_D5M_FVAL   = fval_q;
  assign om_D5M_LVAL   = lval_q;
  assign om_FRAME_DONE = done_q;
  assign om_FRAME_CNT  = fcnt_q;

endmodule
